debounce_bank: RTL and testbench

- Multi-channel push-button conditioner for board-level inputs; the parametrised successor to the single-button debouncer.
- Each channel: 2-FF synchroniser, shared slow sample tick, N-consecutive-sample stability filter, clean level, one-cycle press/release pulses, one-shot long-press pulse.
- Sits between raw FPGA pins and control FSMs; all outputs are synchronous to clk.

---
 rtl/debounce_pkg.sv | 26 ++
 rtl/debounce_chan.sv | 73 +++++++
 rtl/debounce_bank.sv | 64 ++++++
 tb/tb_debounce_bank.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared helpers for the debounce bank: counter width sizing, default widths
// and the elaboration-time parameter legality test.
package debounce_pkg;

  // Bits needed to hold 0..max_val, never fewer than one.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic bit params_legal(input int clk_div, input int stable_cnt,
                                      input int long_cnt);
    return (clk_div >= 1) && (stable_cnt >= 1) && (long_cnt >= 1);
  endfunction

  localparam int DEF_N_CH       = 4;
  localparam int DEF_CLK_DIV    = 250000;
  localparam int DEF_STABLE_CNT = 4;
  localparam int DEF_LONG_CNT   = 100;

  localparam int DEF_TICK_W = cnt_width(DEF_CLK_DIV);
  localparam int DEF_STAB_W = cnt_width(DEF_STABLE_CNT);
  localparam int DEF_HOLD_W = cnt_width(DEF_LONG_CNT);

endpackage

// File: rtl/debounce_chan.sv
// One button channel: 2-FF synchroniser, tick-gated stability filter,
// debounced level with press/release pulses and a one-shot long-press pulse.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int STABLE_CNT = DEF_STABLE_CNT,
  parameter int LONG_CNT   = DEF_LONG_CNT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn_pol,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int STAB_W = cnt_width(STABLE_CNT);
  localparam int HOLD_W = cnt_width(LONG_CNT);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CNT);
  localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_CNT - 1);

  logic              sync1;
  logic              sync2;
  logic [STAB_W-1:0] stab_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              flip;

  // Level toggles on this tick once the disagreement has lasted STABLE_CNT ticks.
  assign flip = tick && (sync2 != level) && (stab_cnt == STAB_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1         <= 1'b0;
      sync2         <= 1'b0;
      stab_cnt      <= '0;
      hold_cnt      <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      sync1         <= btn_pol;
      sync2         <= sync1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      if (tick) begin
        if (sync2 == level) begin
          stab_cnt <= '0;
        end else if (flip) begin
          level         <= ~level;
          stab_cnt      <= '0;
          press_pulse   <= ~level;
          release_pulse <= level;
        end else begin
          stab_cnt <= stab_cnt + STAB_W'(1);
        end

        // A falling tick clears the hold count and wins over a coincident long press.
        if (!level || flip) begin
          hold_cnt <= '0;
        end else if (hold_cnt != HOLD_MAX) begin
          hold_cnt <= hold_cnt + HOLD_W'(1);
          if (hold_cnt == HOLD_PRE) long_pulse <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel push-button conditioner: one shared sample-tick divider
// feeding N_CH independent debounce channels.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int N_CH       = DEF_N_CH,
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int STABLE_CNT = DEF_STABLE_CNT,
  parameter int LONG_CNT   = DEF_LONG_CNT,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_pulse,
  output logic            sample_tick
);

  localparam int TICK_W = cnt_width(CLK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_DIV - 1);

  if (!params_legal(CLK_DIV, STABLE_CNT, LONG_CNT)) begin : g_param_err
    $error("debounce_bank: CLK_DIV, STABLE_CNT and LONG_CNT must all be >= 1");
  end

  logic [TICK_W-1:0] tick_cnt;
  logic [N_CH-1:0]   btn_pol;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // With CLK_DIV=1 the counter sits at 0 == TICK_LAST, so the tick is held high.
  assign sample_tick = (tick_cnt == TICK_LAST);

  // Normalise so that 1 always means pressed from here on.
  assign btn_pol = btn_in ^ {N_CH{ACTIVE_LOW}};

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    debounce_chan #(
      .STABLE_CNT (STABLE_CNT),
      .LONG_CNT   (LONG_CNT)
    ) u_chan (
      .clk           (clk),
      .rst_n         (rst_n),
      .tick          (sample_tick),
      .btn_pol       (btn_pol[i]),
      .level         (btn_level[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .long_pulse    (long_pulse[i])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: directed scenarios plus random button traffic,
// every cycle compared against a sample-window reference model.
module tb_debounce_bank;

  localparam int N  = 4;
  localparam int CD = 4;
  localparam int SC = 3;
  localparam int LC = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         rst1_n;
  logic [N-1:0] btn_in;
  logic [N-1:0] btn1;

  logic [N-1:0] btn_level, press_pulse, release_pulse, long_pulse;
  logic         sample_tick;
  logic [N-1:0] btn_level1, press_pulse1, release_pulse1, long_pulse1;
  logic         sample_tick1;

  debounce_bank #(
    .N_CH(N), .CLK_DIV(CD), .STABLE_CNT(SC), .LONG_CNT(LC), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_in        (btn_in),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .sample_tick   (sample_tick)
  );

  debounce_bank #(
    .N_CH(N), .CLK_DIV(1), .STABLE_CNT(SC), .LONG_CNT(LC), .ACTIVE_LOW(1'b1)
  ) dut1 (
    .clk           (clk),
    .rst_n         (rst1_n),
    .btn_in        (btn1),
    .btn_level     (btn_level1),
    .press_pulse   (press_pulse1),
    .release_pulse (release_pulse1),
    .long_pulse    (long_pulse1),
    .sample_tick   (sample_tick1)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  // Filter input is the pin seen two clocks earlier; a level flips once the
  // last SC tick samples since the previous flip all disagree with it.
  logic [16:0]   exp_q[$];
  logic [N-1:0]  in_q[$];
  int            since_rst;
  int            tick_idx;
  logic [N-1:0]  m_lvl;
  logic [SC-1:0] m_win[N];
  int            m_nvalid[N];
  int            press_idx[N];

  task automatic model_step();
    logic [N-1:0] filt, pr, rl, lg;
    logic         nt, old;
    pr = '0; rl = '0; lg = '0; nt = 1'b0;
    if (!rst_n) begin
      since_rst = 0;
      tick_idx  = 0;
      in_q.delete();
      m_lvl = '0;
      for (int c = 0; c < N; c++) begin
        m_win[c] = '0; m_nvalid[c] = 0; press_idx[c] = 0;
      end
    end else begin
      in_q.push_front(~btn_in);
      if (in_q.size() > 3) void'(in_q.pop_back());
      filt = (in_q.size() > 2) ? in_q[2] : '0;
      if ((since_rst % CD) == CD - 1) begin
        tick_idx++;
        for (int c = 0; c < N; c++) begin
          old = m_lvl[c];
          m_win[c] = {m_win[c][SC-2:0], filt[c]};
          if (m_nvalid[c] < SC) m_nvalid[c]++;
          if (m_nvalid[c] == SC && m_win[c] == {SC{~old}}) begin
            m_lvl[c] = ~old;
            m_nvalid[c] = 0;
            if (!old) begin pr[c] = 1'b1; press_idx[c] = tick_idx; end
            else rl[c] = 1'b1;
          end else if (old && (tick_idx - press_idx[c]) == LC) begin
            lg[c] = 1'b1;
          end
        end
      end
      since_rst++;
      nt = ((since_rst % CD) == CD - 1);
    end
    exp_q.push_back({nt, lg, rl, pr, m_lvl});
  endtask

  // Trailing tick samples that disagree with the current model level.
  function automatic int model_run(input int c);
    int n;
    n = 0;
    for (int k = 0; k < m_nvalid[c]; k++) begin
      if (m_win[c][k] != m_lvl[c]) n++;
      else break;
    end
    return n;
  endfunction

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- scoreboard + pulse counters ----------------
  int p_cnt[N], r_cnt[N], l_cnt[N];
  int p1_cnt;

  initial forever begin
    logic [16:0] e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("outs", 32'({sample_tick, long_pulse, release_pulse, press_pulse, btn_level}), 32'(e));
    end
    for (int c = 0; c < N; c++) begin
      if (press_pulse[c])   p_cnt[c]++;
      if (release_pulse[c]) r_cnt[c]++;
      if (long_pulse[c])    l_cnt[c]++;
    end
    if (press_pulse1[0]) p1_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_cnts();
    for (int c = 0; c < N; c++) begin
      p_cnt[c] = 0; r_cnt[c] = 0; l_cnt[c] = 0;
    end
    p1_cnt = 0;
  endtask

  function automatic bit evt(input int sel, input int c);
    case (sel)
      0:       return press_pulse[c];
      1:       return long_pulse[c];
      2:       return btn_level[c];
      default: return |press_pulse;
    endcase
  endfunction

  // Bounded wait: counts clock edges and tick edges until the event shows up.
  task automatic wait_evt(input string tag, input int sel, input int c, input int max_cyc,
                          output int n_edges, output int n_ticks);
    bit seen;
    n_edges = 0; n_ticks = 0; seen = 1'b0;
    while (!seen && n_edges < max_cyc) begin
      if (sample_tick) n_ticks++;
      cyc(1);
      n_edges++;
      if (evt(sel, c)) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ne, nt, n;
    bit found;
    rst_n = 1'b0; rst1_n = 1'b0;
    btn_in = 4'hF; btn1 = 4'hF;
    clear_cnts();
    cyc(3);
    chk("rst_outs", 32'({sample_tick, long_pulse, release_pulse, press_pulse, btn_level}), 32'd0);
    rst_n = 1'b1; rst1_n = 1'b1;

    for (int c = 1; c <= 8; c++) begin
      cyc(1);
      chk("tick_phase", 32'(sample_tick), 32'((c % CD) == CD - 1));
    end

    // clean press on ch0
    clear_cnts();
    btn_in = 4'hE;
    wait_evt("press0_seen", 2, 0, 40, ne, nt);
    chk("press0_lat", 32'(ne >= 2 + (SC - 1) * CD + 1 && ne <= 2 + SC * CD), 32'd1);
    cyc(10);
    chk("press0_cnt", 32'(p_cnt[0]), 32'd1);
    chk("others_idle", 32'(btn_level[3:1]), 32'd0);

    // glitch on ch1: exactly two ticks low, then three
    clear_cnts();
    btn_in = 4'hC;
    cyc(2 * CD);
    btn_in = 4'hE;
    cyc(24);
    chk("glitch_level", 32'(btn_level[1]), 32'd0);
    chk("glitch_pulses", 32'(p_cnt[1] + r_cnt[1]), 32'd0);
    btn_in = 4'hC;
    cyc(20);
    chk("glitch_press", 32'(p_cnt[1]), 32'd1);
    btn_in = 4'hF;
    cyc(20);
    chk("all_released", 32'(btn_level), 32'd0);

    // long press on ch2, no repeat, release re-arms
    clear_cnts();
    btn_in = 4'hB;
    wait_evt("press2_seen", 0, 2, 40, ne, nt);
    wait_evt("long2_seen", 1, 2, 60, ne, nt);
    chk("long2_ticks", 32'(nt), 32'(LC));
    cyc(20 * CD);
    chk("long2_once", 32'(l_cnt[2]), 32'd1);
    btn_in = 4'hF;
    cyc(20);
    chk("rel2_cnt", 32'(r_cnt[2]), 32'd1);
    btn_in = 4'hB;
    cyc(40);
    chk("long2_rearm", 32'(l_cnt[2]), 32'd2);
    btn_in = 4'hF;
    cyc(20);

    // simultaneous ch0 + ch3
    btn_in = 4'h6;
    wait_evt("simul_seen", 3, 0, 40, ne, nt);
    chk("simul_press", 32'(press_pulse), 32'h9);
    btn_in = 4'hF;
    cyc(20);

    // reset while ch1 is two ticks into its filter
    btn_in = 4'hD;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      cyc(1);
      if (model_run(1) == 2) found = 1'b1;
    end
    chk("midfilt_reached", 32'(found), 32'd1);
    chk("midfilt_no_press", 32'(btn_level[1]), 32'd0);
    rst_n = 1'b0;
    cyc(2);
    chk("midrst_quiet", 32'({press_pulse, release_pulse, btn_level}), 32'd0);
    rst_n = 1'b1;
    wait_evt("postrst_press", 0, 1, 60, ne, nt);
    chk("postrst_ticks", 32'(nt), 32'(SC));
    btn_in = 4'hF;
    cyc(20);

    // random traffic with occasional resets
    for (int it = 0; it < 80; it++) begin
      btn_in = btn_in ^ 4'($urandom_range(0, 15));
      cyc($urandom_range(1, 20));
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 1'b0;
        cyc($urandom_range(1, 3));
        rst_n = 1'b1;
      end
    end
    btn_in = 4'hF;

    // CLK_DIV=1 instance
    clear_cnts();
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      chk("cd1_tick", 32'(sample_tick1), 32'd1);
    end
    btn1 = 4'hE;
    n = 0;
    while (!btn_level1[0] && n < 20) begin
      cyc(1);
      n++;
    end
    chk("cd1_lat", 32'(n), 32'(2 + SC));
    cyc(4);
    chk("cd1_press_cnt", 32'(p1_cnt), 32'd1);

    cyc(3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
